imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_csum.sv | 28 ++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// No logic; no latency; no flow control.
// Imported by imem_loader and imem_loader_csum.
package imem_loader_pkg;

    localparam int         IMEM_DEPTH = 128;
    localparam int         IMEM_AW    = 7;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// Running 8-bit sum of frame bytes; sum_zero looks ahead to include the byte on din.
// Accumulator updates one cycle after each accepted byte; sum_zero is combinational.
// No flow control of its own; the loader decides when bytes count.
module imem_loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       acc_en,
    input  logic [7:0] din,
    output logic       sum_zero
);

    logic [7:0] acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (acc_en) begin
            acc <= acc + din;
        end
    end

    // True when the checksum byte currently on din closes the frame to zero.
    assign sum_zero = ((acc + din) == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader writing 16-bit words into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Write strobe 1 cycle after the low byte is accepted; all outputs registered.
// rx_ready drops for the single WRITE cycle of each word and while in reset.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [15:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [7:0]         word_count
);

    state_t state, next_state;
    logic [7:0] len;
    logic       xfer, start;

    logic               d_rx_ready, d_we, d_hold, d_done, d_err;
    logic [IMEM_AW-1:0] d_addr;
    logic [15:0]        d_wdata;
    logic [7:0]         d_count, d_len;

    assign xfer  = rx_valid && rx_ready;
    assign start = xfer && (rx_data == SYNC_BYTE) &&
                   (state == S_IDLE || state == S_DONE || state == S_ERR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic sum_zero;

    imem_loader_csum u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start),
        .acc_en   (xfer && (state == S_HI || state == S_LO)),
        .din      (rx_data),
        .sum_zero (sum_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len        <= 8'h00;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'h0000;
            word_count <= 8'h00;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state      <= next_state;
            len        <= d_len;
            rx_ready   <= d_rx_ready;
            imem_we    <= d_we;
            imem_addr  <= d_addr;
            imem_wdata <= d_wdata;
            word_count <= d_count;
            load_done  <= d_done;
            load_err   <= d_err;
            cpu_hold   <= d_hold;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN;
            S_LEN: if (xfer) begin
                next_state = (rx_data == 8'h00 || rx_data > 8'(IMEM_DEPTH)) ? S_ERR : S_HI;
            end
            S_HI:  if (xfer) next_state = S_LO;
            S_LO:  if (xfer) next_state = S_WRITE;
            S_WRITE: begin
                // word_count has not yet counted the word being written here.
                if ((word_count + 8'd1) < len) begin
                    next_state = S_HI;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) next_state = sum_zero ? S_DONE : S_ERR;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        d_len      = len;
        d_rx_ready = (next_state != S_WRITE);
        d_we       = (next_state == S_WRITE);
        d_addr     = (next_state == S_WRITE) ? word_count[IMEM_AW-1:0] : imem_addr;
        d_wdata    = imem_wdata;
        d_count    = word_count;
        d_done     = load_done;
        d_err      = load_err;
        d_hold     = cpu_hold;

        if (start) begin
            d_count = 8'h00;
            d_done  = 1'b0;
            d_err   = 1'b0;
            d_hold  = 1'b1;
        end
        if (state == S_LEN && xfer) d_len = rx_data;
        if (state == S_HI && xfer)  d_wdata[15:8] = rx_data;
        if (state == S_LO && xfer)  d_wdata[7:0]  = rx_data;
        if (state == S_WRITE)       d_count = word_count + 8'd1;

        if (next_state == S_DONE && state != S_DONE) begin
            d_done = 1'b1;
            d_hold = 1'b0;
        end
        if (next_state == S_ERR && state != S_ERR) begin
            d_err  = 1'b1;
            d_hold = 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized frames against a frame-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [7:0]  word_count;

    int total = 0;
    int bad   = 0;
    int max_gap = 0;
    int ready_low = 0;
    logic [6:0]  got_addr[$];
    logic [15:0] got_data[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
        if (rx_ready === 1'b0) ready_low++;
    end

    // Clears the write monitor away from the sampling edge; returns on a negedge.
    task automatic clear_mon();
        @(posedge clk);
        #1;
        got_addr.delete();
        got_data.delete();
        ready_low = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Entered and left on a negedge; one byte is transferred in between.
    task automatic send_byte(input logic [7:0] b);
        int gap, waited;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            total++; bad++;
            $display("FAIL rx_ready_timeout: rx_ready=%b required 1 within 50 cycles", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] n, input logic [15:0] w[$]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] sum = 8'h00;
`endif
        send_byte(8'hA5);
        send_byte(n);
        foreach (w[i]) begin
            send_byte(w[i][15:8]);
            send_byte(w[i][7:0]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum = sum + w[i][15:8] + w[i][7:0];
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (rx_ready !== 1'b0)       begin bad++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
        total++; if (imem_we !== 1'b0)        begin bad++; $display("FAIL rst_we: got %b want 0", imem_we); end
        total++; if (imem_addr !== 7'd0)      begin bad++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
        total++; if (imem_wdata !== 16'h0)    begin bad++; $display("FAIL rst_wdata: got %h want 0000", imem_wdata); end
        total++; if (word_count !== 8'd0)     begin bad++; $display("FAIL rst_count: got %0d want 0", word_count); end
        total++; if (load_done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b want 0", load_done); end
        total++; if (load_err !== 1'b0)       begin bad++; $display("FAIL rst_err: got %b want 0", load_err); end
        total++; if (cpu_hold !== 1'b1)       begin bad++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (rx_ready !== 1'b1)       begin bad++; $display("FAIL rst_release_ready: got %b want 1", rx_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] w[$];
        w = '{16'h8022, 16'h8720};
        clear_mon();
        send_frame(8'd2, w);
        idle(3);
        total++; if (got_data.size() != 2) begin bad++; $display("FAIL basic_nwrites: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= got_data.size() || got_addr[i] !== 7'(i) || got_data[i] !== w[i]) begin
                bad++; $display("FAIL basic_write%0d: got %0d writes, want addr %0d data %h", i, got_data.size(), i, w[i]);
            end
        end
        total++; if (word_count !== 8'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", word_count); end
        total++; if (load_done !== 1'b1)  begin bad++; $display("FAIL basic_done: got %b want 1", load_done); end
        total++; if (load_err !== 1'b0)   begin bad++; $display("FAIL basic_err: got %b want 0", load_err); end
        total++; if (cpu_hold !== 1'b0)   begin bad++; $display("FAIL basic_hold: got %b want 0", cpu_hold); end
    endtask

    task automatic test_random_frames();
        logic [15:0] w[$];
        int n, junk;
        logic [7:0] b;
        max_gap = 2;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 12);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            clear_mon();
            junk = $urandom_range(0, 3);
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
            end
            send_frame(8'(n), w);
            idle(3);
            total++; if (got_data.size() != n) begin bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", t, got_data.size(), n); end
            for (int i = 0; i < n; i++) begin
                total++;
                if (i >= got_data.size() || got_addr[i] !== 7'(i) || got_data[i] !== w[i]) begin
                    bad++; $display("FAIL rand%0d_write%0d: got %0d writes, want addr %0d data %h", t, i, got_data.size(), i, w[i]);
                end
            end
            total++;
            if (word_count !== 8'(n) || load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
                bad++; $display("FAIL rand%0d_status: count=%0d done=%b err=%b hold=%b want %0d/1/0/0", t, word_count, load_done, load_err, cpu_hold, n);
            end
        end
        max_gap = 0;
    endtask

    task automatic test_len_errors();
        logic [15:0] w[$];
        clear_mon();
        send_byte(8'hA5); send_byte(8'h00);
        idle(3);
        total++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            bad++; $display("FAIL len0_status: err=%b hold=%b done=%b want 1/1/0", load_err, cpu_hold, load_done); end
        total++; if (got_data.size() != 0) begin bad++; $display("FAIL len0_writes: got %0d want 0", got_data.size()); end
        w = '{16'($urandom)};
        send_frame(8'd1, w);
        idle(3);
        total++; if (load_done !== 1'b1 || load_err !== 1'b0 || got_data.size() != 1) begin
            bad++; $display("FAIL len0_recover: done=%b err=%b writes=%0d want 1/0/1", load_done, load_err, got_data.size()); end
        clear_mon();
        send_byte(8'hA5); send_byte(8'd129);
        idle(3);
        total++; if (load_err !== 1'b1 || word_count !== 8'd0 || got_data.size() != 0) begin
            bad++; $display("FAIL len129: err=%b count=%0d writes=%0d want 1/0/0", load_err, word_count, got_data.size()); end
    endtask

    task automatic test_resync();
        clear_mon();
        send_byte(8'h55); send_byte(8'hA5); send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        idle(3);
        total++; if (load_err !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++; $display("FAIL resync_status: err=%b done=%b hold=%b want 1/0/1", load_err, load_done, cpu_hold); end
        total++; if (got_data.size() != 0) begin bad++; $display("FAIL resync_writes: got %0d want 0", got_data.size()); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        idle(3);
        total++; if (got_data.size() != 1 || got_data[0] !== 16'h1234 || got_addr[0] !== 7'd0) begin
            bad++; $display("FAIL csum_write: writes=%0d want one write 1234 at 0", got_data.size()); end
        total++; if (load_err !== 1'b1 || load_done !== 1'b0) begin
            bad++; $display("FAIL csum_status: err=%b done=%b want 1/0", load_err, load_done); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] w[$];
        int bad_addr;
        for (int i = 0; i < 128; i++) w.push_back(16'($urandom));
        max_gap = 0;
        clear_mon();
        send_frame(8'd128, w);
        idle(3);
        total++; if (got_data.size() != 128) begin bad++; $display("FAIL full_nwrites: got %0d want 128", got_data.size()); end
        bad_addr = 0;
        for (int i = 0; i < 128 && i < got_data.size(); i++)
            if (got_addr[i] !== 7'(i) || got_data[i] !== w[i]) bad_addr++;
        total++; if (bad_addr != 0) begin bad++; $display("FAIL full_writes: %0d wrong entries want 0", bad_addr); end
        total++; if (ready_low != 128) begin bad++; $display("FAIL full_ready_low: got %0d want 128", ready_low); end
        total++; if (word_count !== 8'd128 || load_done !== 1'b1) begin
            bad++; $display("FAIL full_status: count=%0d done=%b want 128/1", word_count, load_done); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w[$];
        for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
        clear_mon();
        send_byte(8'hA5); send_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            send_byte(w[i][15:8]); send_byte(w[i][7:0]);
        end
        send_byte(w[3][15:8]);
        total++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || got_data.size() != 3) begin
            bad++; $display("FAIL mid_progress: hold=%b done=%b writes=%0d want 1/0/3", cpu_hold, load_done, got_data.size()); end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 7'd0 || imem_wdata !== 16'h0 ||
            word_count !== 8'd0 || load_done !== 1'b0 || load_err !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++; $display("FAIL mid_reset_vals: rdy=%b we=%b addr=%0d wd=%h cnt=%0d done=%b err=%b hold=%b",
                            rx_ready, imem_we, imem_addr, imem_wdata, word_count, load_done, load_err, cpu_hold);
        end
        rst_n = 1'b1;
        clear_mon();
        send_byte(w[3][7:0]); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle(4);
        total++; if (got_data.size() != 0) begin bad++; $display("FAIL mid_no_write: got %0d want 0", got_data.size()); end
        send_frame(8'd5, w);
        idle(3);
        total++; if (got_data.size() != 5 || load_done !== 1'b1 || got_data[4] !== w[4]) begin
            bad++; $display("FAIL mid_recover: writes=%0d done=%b want 5/1", got_data.size(), load_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_frames();
        test_len_errors();
        test_resync();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
